// File: rtl/scurve_scan_ctrl.sv
// S-curve threshold scan sequencer: steps the DAC code, runs acquisition windows per code
// through the slave DAQ and emits one {code, hit count} result word per point.
`timescale 1ns/1ps
module scurve_scan_ctrl #(
    parameter int unsigned DAC_WIDTH   = 10,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   ScanStart,
    input  logic                   ScanStop,
    input  logic [DAC_WIDTH-1:0]   DacStart,
    input  logic [DAC_WIDTH-1:0]   DacEnd,
    input  logic [DAC_WIDTH-1:0]   DacStep,
    input  logic [COUNT_WIDTH-1:0] WindowsPerPoint,
    output logic [DAC_WIDTH-1:0]   DacCode,
    output logic                   ConfigStart,
    input  logic                   ConfigDone,
    output logic                   AcqStart,
    input  logic                   OnceEnd,
    input  logic                   TrigHit,
    output logic [31:0]            ResultData,
    output logic                   ResultValid,
    input  logic                   ResultReady,
    output logic                   ScanBusy,
    output logic                   ScanDone
);
    typedef enum logic [2:0] {
        IDLE, CONFIG, WAIT_CFG, ACQ, WAIT_END, WRITE, NEXT, DONE
    } scanState_t;

    scanState_t               state;
    logic [DAC_WIDTH-1:0]     dacEndQ;
    logic [DAC_WIDTH-1:0]     dacStepQ;
    logic [COUNT_WIDTH-1:0]   winTarget;
    logic [COUNT_WIDTH-1:0]   winCnt;
    logic [COUNT_WIDTH-1:0]   hitCount;
    logic [DAC_WIDTH:0]       stepSum;
    logic [COUNT_WIDTH:0]     winNext;
    logic                     hitEn;

    // Extra bit on the step sum so the last-point test sees codes that would wrap.
    assign stepSum    = {1'b0, DacCode} + {1'b0, dacStepQ};
    assign winNext    = {1'b0, winCnt} + (COUNT_WIDTH + 1)'(1);
    assign hitEn      = TrigHit && ((state == ACQ) || (state == WAIT_END)) && (hitCount != '1);
    assign ResultData = 32'({DacCode, hitCount});

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dacEndQ     <= '0;
            dacStepQ    <= '0;
            winTarget   <= '0;
            winCnt      <= '0;
            hitCount    <= '0;
            DacCode     <= '0;
            ConfigStart <= 1'b0;
            AcqStart    <= 1'b0;
            ResultValid <= 1'b0;
            ScanBusy    <= 1'b0;
            ScanDone    <= 1'b0;
        end else if (ScanStop && (state != IDLE)) begin
            // Abort wins over everything; DacCode keeps its last value.
            state       <= IDLE;
            ConfigStart <= 1'b0;
            AcqStart    <= 1'b0;
            ResultValid <= 1'b0;
            ScanBusy    <= 1'b0;
            ScanDone    <= 1'b0;
        end else begin
            if (hitEn) begin
                hitCount <= hitCount + COUNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (ScanStart && !ScanStop) begin
                        DacCode     <= DacStart;
                        dacEndQ     <= DacEnd;
                        dacStepQ    <= (DacStep == '0) ? DAC_WIDTH'(1) : DacStep;
                        winTarget   <= (WindowsPerPoint == '0) ? COUNT_WIDTH'(1) : WindowsPerPoint;
                        ConfigStart <= 1'b1;
                        ScanBusy    <= 1'b1;
                        state       <= CONFIG;
                    end
                end
                CONFIG: begin
                    ConfigStart <= 1'b0;
                    state       <= WAIT_CFG;
                end
                WAIT_CFG: begin
                    if (ConfigDone) begin
                        hitCount <= '0;
                        winCnt   <= '0;
                        AcqStart <= 1'b1;
                        state    <= ACQ;
                    end
                end
                ACQ: begin
                    AcqStart <= 1'b0;
                    state    <= WAIT_END;
                end
                WAIT_END: begin
                    if (OnceEnd) begin
                        winCnt <= winNext[COUNT_WIDTH-1:0];
                        if (winNext >= {1'b0, winTarget}) begin
                            ResultValid <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            AcqStart <= 1'b1;
                            state    <= ACQ;
                        end
                    end
                end
                WRITE: begin
                    if (ResultReady) begin
                        ResultValid <= 1'b0;
                        state       <= NEXT;
                    end
                end
                NEXT: begin
                    if ((DacCode >= dacEndQ) || (stepSum > {1'b0, dacEndQ})) begin
                        ScanDone <= 1'b1;
                        state    <= DONE;
                    end else begin
                        DacCode     <= stepSum[DAC_WIDTH-1:0];
                        ConfigStart <= 1'b1;
                        state       <= CONFIG;
                    end
                end
                DONE: begin
                    ScanDone <= 1'b0;
                    ScanBusy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    ScanBusy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
